pfpu32_opunpack: RTL and testbench
==================================

# pfpu32_opunpack

Single-stage registered operand-unpack front end for the pfpu32 floating-point unit. It accepts two raw IEEE-754 single-precision operands and an FPU opcode, classifies and unpacks each operand into sign / 10-bit exponent / 24-bit fraction plus NaN/Inf/zero flags, and decodes the comparison controls. Its registered outputs drive the comparator (`pfpu32_fcmp`) and add/sub stages directly, with valid/ready handshaking and pipeline flush.

## Interface
Parameters:
- none (all widths fixed by `OR1K_FPUOP_WIDTH` / `OR1K_FPUOP_GENERIC_CMP_WIDTH`)

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1 — clock, all state on rising edge
- `rst` in 1 — synchronous active-high reset
- `flush_i` in 1 — pipeline flush, discards held operand
- `valid_i` in 1 — upstream presents operands
- `ready_o` out 1 — stage can accept
- `opc_i` in `OR1K_FPUOP_WIDTH` — FPU opcode
- `rfa_i` in 32 — raw operand a
- `rfb_i` in 32 — raw operand b
- `valid_o` out 1 — unpacked result held
- `ready_i` in 1 — downstream consumes
- `fpu_op_is_comp_o` out 1 — op is a compare
- `generic_cmp_opc_o` out `OR1K_FPUOP_GENERIC_CMP_WIDTH` — `opc_i[OR1K_FPUOP_GENERIC_CMP_SELECT]`
- `unordered_cmp_bit_o` out 1 — unordered compare
- `signa_o`/`signb_o` out 1 — sign
- `exp10a_o`/`exp10b_o` out 10 — unpacked exponent
- `fract24a_o`/`fract24b_o` out 24 — fraction with hidden bit
- `snana_o`/`snanb_o`, `qnana_o`/`qnanb_o`, `infa_o`/`infb_o`, `zeroa_o`/`zerob_o` out 1 — classification
- `dena_o`/`denb_o` out 1 — operand was denormal (pre-DAZ)

## Operation
- Per operand, with e = bits[30:23] and m = bits[22:0]:
  - sign = bit 31.
  - e==0xFF, m!=0: NaN; qnan = m[22], snan = ~m[22].
  - e==0xFF, m==0: inf.
  - e==0, m==0: zero.
  - e==0, m!=0: denormal, den = 1.
- exp10 = {2'b00, e} when e != 0; 10'd1 when e == 0 (zeros and denormals).
- fract24 = {e != 0, m}.
- Classification flags are mutually exclusive per operand.
- Compare decode:
  - `fpu_op_is_comp_o` = `opc_i[PFPU32_OPC_CMP_BIT]`.
  - `unordered_cmp_bit_o` = `opc_i[PFPU32_OPC_UNORD_BIT]`.
  - Both are gated to 0 when `valid_o` is 0.
- Handshake:
  - `ready_o` = ~`valid_o` | `ready_i`.
  - Load occurs when `valid_i` & `ready_o`; the register then captures all outputs and sets `valid_o`.
  - Consume occurs when `valid_o` & `ready_i` with no load: `valid_o` clears.
  - Simultaneous consume and load: the new data replaces the old and `valid_o` stays 1.
  - Output data is stable while `valid_o` & ~`ready_i`.
- Flush: `flush_i` clears `valid_o` next cycle and blocks any load in the same cycle (flush wins). `ready_o` is forced to 0 during flush.
- Reset: `valid_o`=0 and all data outputs 0, except `exp10*_o`=10'd1. Reset applies mid-transfer identically.

## Timing
- Latency 1 cycle from accepted `valid_i` to `valid_o`; throughput 1 per cycle with `ready_i` held high.
- `ready_o` is combinational from `valid_o`, `ready_i` and `flush_i`. No other comb path input→output.
- Data outputs are pure registers. Enable = load; no enable toggle on stall.

## Configuration
- `PFPU32_DAZ_EN` defined: a denormal operand is unpacked as a zero of the same sign.
  - zero=1, fract24=0, exp10=1.
  - `den*_o` still reports 1.
- Undefined: denormals pass through unpacked as described above, with zero=0.

## Structure
- Shared package `pfpu32_pkg` holds:
  - `PFPU32_OPC_CMP_BIT`=3 and `PFPU32_OPC_UNORD_BIT`=5;
  - the `pfpu32_unpacked_t` struct (sign, exp10, fract24, snan, qnan, inf, zero, den);
  - the `PFPU32_EXP_NAN`=8'hFF constant.
- One sub-module `pfpu32_unpack_one`, combinational, instantiated twice (a, b). The top holds only the handshake register and opcode decode.

## Test plan
- Normal operands: a=0x3F800000 → sign 0, exp10 0x07F, fract24 0x800000, all flags 0, valid_o after 1 cycle.
- a=0x7F800001, b=0x7FC00000 → snana=1, qnanb=1, exp10 0x0FF both, infa/infb=0.
- Denormal b=0x00000001:
  - without DAZ → exp10b 1, fract24b 0x000001, zerob 0, denb 1;
  - with `PFPU32_DAZ_EN` → zerob 1, fract24b 0, denb 1.
- a=0x80000000, b=0xFF800000 → signa 1, zeroa 1, infb 1, signb 1.
- Backpressure:
  - ready_i=0 for 3 cycles after load → outputs frozen, ready_o=0;
  - ready_i=1 with new valid_i → back-to-back replace, valid_o stays 1.
- Flush asserted together with valid_i on a loaded stage → valid_o=0 next cycle, new data not captured. Reset mid-stall → valid_o=0, exp10 outputs=1.

Source files
------------

// File: rtl/pfpu32_pkg.sv
// Shared types and constants for the pfpu32 operand-unpack front end.
package pfpu32_pkg;

    localparam int unsigned OR1K_FPUOP_WIDTH             = 8;
    localparam int unsigned OR1K_FPUOP_GENERIC_CMP_WIDTH = 3;
    localparam int unsigned PFPU32_OPC_CMP_BIT           = 3;
    localparam int unsigned PFPU32_OPC_UNORD_BIT         = 5;
    localparam logic [7:0]  PFPU32_EXP_NAN               = 8'hFF;

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp10;
        logic [23:0] fract24;
        logic        snan;
        logic        qnan;
        logic        inf;
        logic        zero;
        logic        den;
    } pfpu32_unpacked_t;

    // Idle value of an unpacked operand: zero with the minimum biased exponent.
    function automatic pfpu32_unpacked_t pfpu32_unpacked_rst();
        pfpu32_unpacked_t r;
        r       = '0;
        r.exp10 = 10'd1;
        return r;
    endfunction

endpackage

// File: rtl/pfpu32_unpack_one.sv
// Combinational classify/unpack of one IEEE-754 single operand.
// Optional build macro: PFPU32_DAZ_EN (denormals unpacked as signed zero).
module pfpu32_unpack_one
    import pfpu32_pkg::*;
(
    input  logic [31:0]      opnd_i,
    output pfpu32_unpacked_t unp_o
);

    logic [7:0]  e;
    logic [22:0] m;
    logic        e_max;
    logic        e_zero;
    logic        m_zero;

    assign e      = opnd_i[30:23];
    assign m      = opnd_i[22:0];
    assign e_max  = (e == PFPU32_EXP_NAN);
    assign e_zero = (e == 8'h00);
    assign m_zero = (m == 23'd0);

    always_comb begin
        unp_o         = '0;
        unp_o.sign    = opnd_i[31];
        unp_o.exp10   = e_zero ? 10'd1 : {2'b00, e};
        unp_o.snan    = e_max & ~m_zero & ~m[22];
        unp_o.qnan    = e_max & m[22];
        unp_o.inf     = e_max & m_zero;
        unp_o.den     = e_zero & ~m_zero;
`ifdef PFPU32_DAZ_EN
        unp_o.zero    = e_zero;
        unp_o.fract24 = e_zero ? 24'd0 : {1'b1, m};
`else
        unp_o.zero    = e_zero & m_zero;
        unp_o.fract24 = {~e_zero, m};
`endif
    end

endmodule

// File: rtl/pfpu32_opunpack.sv
// Registered operand-unpack stage with valid/ready handshake and flush.
// Optional build macro: PFPU32_DAZ_EN (handled in pfpu32_unpack_one).
module pfpu32_opunpack
    import pfpu32_pkg::*;
(
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush_i,
    input  logic                                    valid_i,
    output logic                                    ready_o,
    input  logic [OR1K_FPUOP_WIDTH-1:0]             opc_i,
    input  logic [31:0]                             rfa_i,
    input  logic [31:0]                             rfb_i,
    output logic                                    valid_o,
    input  logic                                    ready_i,
    output logic                                    fpu_op_is_comp_o,
    output logic [OR1K_FPUOP_GENERIC_CMP_WIDTH-1:0] generic_cmp_opc_o,
    output logic                                    unordered_cmp_bit_o,
    output logic                                    signa_o,
    output logic                                    signb_o,
    output logic [9:0]                              exp10a_o,
    output logic [9:0]                              exp10b_o,
    output logic [23:0]                             fract24a_o,
    output logic [23:0]                             fract24b_o,
    output logic                                    snana_o,
    output logic                                    snanb_o,
    output logic                                    qnana_o,
    output logic                                    qnanb_o,
    output logic                                    infa_o,
    output logic                                    infb_o,
    output logic                                    zeroa_o,
    output logic                                    zerob_o,
    output logic                                    dena_o,
    output logic                                    denb_o
);

    pfpu32_unpacked_t unpa_d, unpb_d;
    pfpu32_unpacked_t unpa_q, unpb_q;
    logic [OR1K_FPUOP_GENERIC_CMP_WIDTH-1:0] gcmp_q;
    logic comp_q, unord_q;
    logic valid_q, valid_d;
    logic load;

    logic unused_opc;
    assign unused_opc = ^{opc_i[7:6], opc_i[4]};

    pfpu32_unpack_one u_unpack_a (.opnd_i(rfa_i), .unp_o(unpa_d));
    pfpu32_unpack_one u_unpack_b (.opnd_i(rfb_i), .unp_o(unpb_d));

    assign ready_o = ~flush_i & (~valid_q | ready_i);
    assign load    = valid_i & ready_o;

    always_comb begin
        valid_d = valid_q;
        if (flush_i)
            valid_d = 1'b0;
        else if (load)
            valid_d = 1'b1;
        else if (ready_i)
            valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            valid_q <= 1'b0;
        else
            valid_q <= valid_d;
    end

    // Data registers load only on an accepted transfer, so they hold through stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            unpa_q  <= pfpu32_unpacked_rst();
            unpb_q  <= pfpu32_unpacked_rst();
            gcmp_q  <= '0;
            comp_q  <= 1'b0;
            unord_q <= 1'b0;
        end else if (load) begin
            unpa_q  <= unpa_d;
            unpb_q  <= unpb_d;
            gcmp_q  <= opc_i[OR1K_FPUOP_GENERIC_CMP_WIDTH-1:0];
            comp_q  <= opc_i[PFPU32_OPC_CMP_BIT];
            unord_q <= opc_i[PFPU32_OPC_UNORD_BIT];
        end
    end

    assign valid_o             = valid_q;
    assign fpu_op_is_comp_o    = comp_q & valid_q;
    assign unordered_cmp_bit_o = unord_q & valid_q;
    assign generic_cmp_opc_o   = gcmp_q;

    assign signa_o    = unpa_q.sign;
    assign exp10a_o   = unpa_q.exp10;
    assign fract24a_o = unpa_q.fract24;
    assign snana_o    = unpa_q.snan;
    assign qnana_o    = unpa_q.qnan;
    assign infa_o     = unpa_q.inf;
    assign zeroa_o    = unpa_q.zero;
    assign dena_o     = unpa_q.den;

    assign signb_o    = unpb_q.sign;
    assign exp10b_o   = unpb_q.exp10;
    assign fract24b_o = unpb_q.fract24;
    assign snanb_o    = unpb_q.snan;
    assign qnanb_o    = unpb_q.qnan;
    assign infb_o     = unpb_q.inf;
    assign zerob_o    = unpb_q.zero;
    assign denb_o     = unpb_q.den;

endmodule

// File: tb/tb_pfpu32_opunpack.sv
// Scoreboard bench for pfpu32_opunpack; honours PFPU32_DAZ_EN when defined.
module tb_pfpu32_opunpack;
    import pfpu32_pkg::*;

    typedef struct packed {
        logic [2:0]       gcmp;
        logic             comp;
        logic             unord;
        pfpu32_unpacked_t a;
        pfpu32_unpacked_t b;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst, flush_i, valid_i, ready_i;
    logic        ready_o, valid_o;
    logic [7:0]  opc_i;
    logic [31:0] rfa_i, rfb_i;
    logic        fpu_op_is_comp_o, unordered_cmp_bit_o;
    logic [2:0]  generic_cmp_opc_o;
    logic        signa_o, signb_o;
    logic [9:0]  exp10a_o, exp10b_o;
    logic [23:0] fract24a_o, fract24b_o;
    logic        snana_o, snanb_o, qnana_o, qnanb_o;
    logic        infa_o, infb_o, zeroa_o, zerob_o, dena_o, denb_o;

    int total = 0;
    int bad   = 0;
    obs_t exp_q[$];

    logic [31:0] va[6];
    logic [31:0] vb[6];
    logic [7:0]  vop[6];
    obs_t        vexp[6];

    pfpu32_opunpack dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .opc_i(opc_i), .rfa_i(rfa_i), .rfb_i(rfb_i), .valid_o(valid_o), .ready_i(ready_i),
        .fpu_op_is_comp_o(fpu_op_is_comp_o), .generic_cmp_opc_o(generic_cmp_opc_o),
        .unordered_cmp_bit_o(unordered_cmp_bit_o),
        .signa_o(signa_o), .signb_o(signb_o), .exp10a_o(exp10a_o), .exp10b_o(exp10b_o),
        .fract24a_o(fract24a_o), .fract24b_o(fract24b_o),
        .snana_o(snana_o), .snanb_o(snanb_o), .qnana_o(qnana_o), .qnanb_o(qnanb_o),
        .infa_o(infa_o), .infb_o(infb_o), .zeroa_o(zeroa_o), .zerob_o(zerob_o),
        .dena_o(dena_o), .denb_o(denb_o)
    );

    always #5 clk = ~clk;

    function automatic pfpu32_unpacked_t mk(logic s, logic [9:0] e, logic [23:0] f,
                                            logic sn, logic qn, logic inf, logic z, logic den);
        pfpu32_unpacked_t r;
        r.sign = s; r.exp10 = e; r.fract24 = f;
        r.snan = sn; r.qnan = qn; r.inf = inf; r.zero = z; r.den = den;
        return r;
    endfunction

    function automatic obs_t mko(logic [2:0] g, logic c, logic u,
                                 pfpu32_unpacked_t a, pfpu32_unpacked_t b);
        obs_t o;
        o.gcmp = g; o.comp = c; o.unord = u; o.a = a; o.b = b;
        return o;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int i, bit push);
        rfa_i   = va[i];
        rfb_i   = vb[i];
        opc_i   = vop[i];
        valid_i = 1'b1;
        if (push) exp_q.push_back(vexp[i]);
    endtask

    // Monitor: a held result leaves either by transfer (checked) or by flush/reset (dropped).
    always @(negedge clk) begin
        obs_t act, e;
        act.gcmp  = generic_cmp_opc_o;
        act.comp  = fpu_op_is_comp_o;
        act.unord = unordered_cmp_bit_o;
        act.a = mk(signa_o, exp10a_o, fract24a_o, snana_o, qnana_o, infa_o, zeroa_o, dena_o);
        act.b = mk(signb_o, exp10b_o, fract24b_o, snanb_o, qnanb_o, infb_o, zerob_o, denb_o);
        if (valid_o && (rst || flush_i)) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (valid_o && ready_i) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL xfer unexpected act=%h req=none", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    bad++;
                    $display("FAIL xfer data act=%h req=%h", act, e);
                end
            end
        end
    end

    initial begin
        va[0] = 32'h3F800000; vb[0] = 32'h40000000; vop[0] = 8'h00;
        vexp[0] = mko(3'd0, 1'b0, 1'b0, mk(0, 10'h07F, 24'h800000, 0, 0, 0, 0, 0),
                                        mk(0, 10'h080, 24'h800000, 0, 0, 0, 0, 0));
        va[1] = 32'h7F800001; vb[1] = 32'h7FC00000; vop[1] = 8'h08;
        vexp[1] = mko(3'd0, 1'b1, 1'b0, mk(0, 10'h0FF, 24'h800001, 1, 0, 0, 0, 0),
                                        mk(0, 10'h0FF, 24'hC00000, 0, 1, 0, 0, 0));
        va[2] = 32'h3F800000; vb[2] = 32'h00000001; vop[2] = 8'h2B;
`ifdef PFPU32_DAZ_EN
        vexp[2] = mko(3'd3, 1'b1, 1'b1, mk(0, 10'h07F, 24'h800000, 0, 0, 0, 0, 0),
                                        mk(0, 10'h001, 24'h000000, 0, 0, 0, 1, 1));
`else
        vexp[2] = mko(3'd3, 1'b1, 1'b1, mk(0, 10'h07F, 24'h800000, 0, 0, 0, 0, 0),
                                        mk(0, 10'h001, 24'h000001, 0, 0, 0, 0, 1));
`endif
        va[3] = 32'h80000000; vb[3] = 32'hFF800000; vop[3] = 8'h0D;
        vexp[3] = mko(3'd5, 1'b1, 1'b0, mk(1, 10'h001, 24'h000000, 0, 0, 0, 1, 0),
                                        mk(1, 10'h0FF, 24'h800000, 0, 0, 1, 0, 0));
        va[4] = 32'hC0490FDB; vb[4] = 32'h00800000; vop[4] = 8'h20;
        vexp[4] = mko(3'd0, 1'b0, 1'b1, mk(1, 10'h080, 24'hC90FDB, 0, 0, 0, 0, 0),
                                        mk(0, 10'h001, 24'h800000, 0, 0, 0, 0, 0));
        va[5] = 32'h7F800000; vb[5] = 32'h807FFFFF; vop[5] = 8'h07;
`ifdef PFPU32_DAZ_EN
        vexp[5] = mko(3'd7, 1'b0, 1'b0, mk(0, 10'h0FF, 24'h800000, 0, 0, 1, 0, 0),
                                        mk(1, 10'h001, 24'h000000, 0, 0, 0, 1, 1));
`else
        vexp[5] = mko(3'd7, 1'b0, 1'b0, mk(0, 10'h0FF, 24'h800000, 0, 0, 1, 0, 0),
                                        mk(1, 10'h001, 24'h7FFFFF, 0, 0, 0, 0, 1));
`endif

        rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        opc_i = 8'h00; rfa_i = '0; rfb_i = '0;
        tick(); tick();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_exp10a", 32'(exp10a_o), 32'd1);
        chk("rst_exp10b", 32'(exp10b_o), 32'd1);
        chk("rst_fract24a", 32'(fract24a_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_comp", 32'(fpu_op_is_comp_o), 32'd0);
        rst = 1'b0;

        // Streaming with ready_i high: one result per cycle.
        drive(0, 1); tick();
        chk("latency_valid", 32'(valid_o), 32'd1);
        drive(1, 1); tick();
        drive(2, 1); tick();
        valid_i = 1'b0;
        chk("stream_valid", 32'(valid_o), 32'd1);
        tick();
        chk("drain_valid", 32'(valid_o), 32'd0);
        chk("idle_comp_gated", 32'(fpu_op_is_comp_o), 32'd0);

        // Backpressure: offered operands must not be captured while stalled.
        ready_i = 1'b0;
        drive(3, 1); tick();
        drive(0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", 32'(ready_o), 32'd0);
            tick();
            chk("stall_valid", 32'(valid_o), 32'd1);
            chk("stall_signa", 32'(signa_o), 32'd1);
            chk("stall_exp10b", 32'(exp10b_o), 32'h0FF);
        end
        drive(4, 1); ready_i = 1'b1;
        #1;
        chk("release_ready", 32'(ready_o), 32'd1);
        tick();
        chk("replace_valid", 32'(valid_o), 32'd1);
        chk("replace_fract24a", 32'(fract24a_o), 32'hC90FDB);
        valid_i = 1'b0;
        tick();

        // Flush on a loaded stage, with a competing load.
        ready_i = 1'b0;
        drive(5, 1); tick();
        drive(0, 0); flush_i = 1'b1;
        #1;
        chk("flush_ready", 32'(ready_o), 32'd0);
        tick();
        flush_i = 1'b0; valid_i = 1'b0;
        chk("flush_valid", 32'(valid_o), 32'd0);
        chk("flush_noload", 32'(exp10a_o), 32'h0FF);

        // Reset while a result is stalled.
        drive(4, 1); tick();
        valid_i = 1'b0; tick();
        chk("prerst_valid", 32'(valid_o), 32'd1);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_exp10a", 32'(exp10a_o), 32'd1);
        chk("midrst_exp10b", 32'(exp10b_o), 32'd1);
        chk("midrst_signa", 32'(signa_o), 32'd0);

        ready_i = 1'b1;
        drive(2, 1); tick();
        valid_i = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
